limd_mc: RTL and testbench
==========================

Name: limd_mc

Overview:
- Parametrised, multi-channel, pipelined successor to the single-channel a1 limiter in the G.726 ADPCM adaptive predictor path.
- Clamps the first-order predictor coefficient A1T to ±(OME − A2P), time-multiplexed over NCH channels.
- Uses valid/ready handshakes on both sides.
- Keeps per-channel saturating clamp-event counters for system monitoring.
- Sits between the a1 update logic (UPA1) and the A1 delay register in each channel slot.

Parameters:
- W, 16, coefficient width (two's complement).
- OME, 15360, upper-limit constant (1 − 2^-4 in Q14 for W=16).
- NCH, 4, channel count (≥1).
- CNT_W, 8, clamp-counter width per channel.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset=0 clears on clk rising edge)
- scan_in0..scan_in4  in  1 each  DFT scan inputs
- scan_enable  in  1  DFT scan enable
- test_mode  in  1  DFT test mode
- scan_out0..scan_out4  out  1 each  DFT scan outputs, driven 0 pre-insertion
- in_valid  in  1  input sample valid
- in_ready  out  1  pipeline can accept input
- in_ch  in  clog2(NCH) (min 1)  channel id of input sample
- A1T  in  W  unlimited a1 coefficient
- A2P  in  W  limited a2 coefficient, same channel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_ch  out  clog2(NCH)  channel id of result
- A1P  out  W  limited a1 coefficient
- out_clamp  out  2  {hi, lo} clamp flags (see Optional Feature)
- stat_ch  in  clog2(NCH)  counter readback select
- stat_clr  in  1  clear counter of stat_ch
- stat_cnt  out  CNT_W  clamp count of stat_ch (combinational read)

Behaviour:
- Arithmetic, all modulo 2^W:
  - A1UL = OME − A2P.
  - A1LL = 2^W − A1UL.
- Selection, in priority order:
  - A1T MSB=1 and A1T ≤ A1LL (unsigned compare) → A1P = A1LL (lo clamp).
  - A1T MSB=0 and A1T ≥ A1UL (unsigned compare) → A1P = A1UL (hi clamp).
  - Otherwise A1P = A1T.
- Pipeline:
  - S1 registers A1T, ch and A1UL/A1LL.
  - S2 registers A1P, ch and clamp flags.
  - Latency is 2 cycles from in_valid&&in_ready to out_valid, with no stall.
- Handshake:
  - Input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
  - in_ready = !s2_valid || out_ready. The whole pipe advances together; bubbles in S1 are not collapsed.
  - Sustains 1 sample/cycle when out_ready=1.
- Stall: with out_valid=1 and out_ready=0, A1P, out_ch, out_clamp and S1 contents hold stable. in_ready=0.
- in_valid=0 with in_ready=1 inserts a bubble, and s1_valid clears.
- Counters:
  - On each S2 load with either clamp flag set, cnt[ch] increments.
  - Counters saturate at 2^CNT_W − 1; no wrap.
  - stat_clr zeroes cnt[stat_ch] next cycle.
  - stat_clr on the same channel and cycle as an increment: the clear wins.
- Reset (reset=0, synchronous):
  - out_valid=0, s1_valid=0, A1P=0, out_ch=0, out_clamp=0, all cnt=0.
  - in_ready=1 after reset.
  - Reset mid-transfer discards in-flight samples; no output is produced for them.
- in_ch ≥ NCH (non-power-of-2 NCH): the sample is limited and output normally; no counter is updated.

Optional Feature:
- Macro LIMD_CLAMP_FLAG_EN.
- Defined: out_clamp carries {hi, lo} for the current output, valid with out_valid.
- Undefined: out_clamp is tied 2'b00. The clamp counters still operate using internal flags.

Test Plan:
- Hi clamp, lo clamp and pass-through (ch0) — checks A1P:
  - A2P=0x0000, A1T=0x4000 → A1P=0x3C00 two cycles later, hi flag, cnt[0]=1.
  - A2P=0x0000, A1T=0xC000 → A1P=0xC400, lo flag.
  - A2P=0xE000, A1T=0x5000 → A1P=0x5000, no flag.
- Channel interleave at full rate:
  - Inputs ch0..ch3 back-to-back with out_ready=1 → outputs in order at 1/cycle, out_ch matching, latency exactly 2.
- Backpressure:
  - Hold out_ready=0 for 3 cycles mid-stream → A1P/out_ch frozen, in_ready=0.
  - On release, no sample is lost or duplicated.
- Counter saturation (CNT_W=4):
  - 20 hi clamps on ch2 → stat_cnt=15 with stat_ch=2.
  - stat_clr → 0; clear coincident with a clamp on ch2 → 0.
- Reset mid-operation:
  - Assert reset=0 with 2 samples in flight → out_valid=0 next cycle, counters 0.
  - After release, the first new sample appears 2 cycles after acceptance.
- Vector regression: replay the ADPCM a1t/a2p/a1p vector sets for all rates and laws on ch0 → A1P matches a1p.t for every entry.

Source files
------------

// File: rtl/limd_mc.sv
`default_nettype none
// ============================================================================
// limd_mc : multi-channel pipelined G.726 a1 limiter, A1P = clamp(A1T, +/-(OME-A2P))
// Optional macro LIMD_CLAMP_FLAG_EN exports the {hi, lo} clamp flags on out_clamp.
// Revision: 1.0
// ============================================================================
module limd_mc #(
  parameter int W     = 16,
  parameter int OME   = 15360,
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  input  logic             scan_enable,
  input  logic             test_mode,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [W-1:0]     A1T,
  input  logic [W-1:0]     A2P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [W-1:0]     A1P,
  output logic [1:0]       out_clamp,
  input  logic [CH_W-1:0]  stat_ch,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_cnt
);

  localparam logic [W-1:0] OME_W = W'(OME);

  logic unused_dft;
  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic            s1_valid_q, s1_valid_d;
  logic [W-1:0]    s1_a1t_q, s1_a1t_d;
  logic [W-1:0]    s1_ul_q, s1_ul_d;
  logic [W-1:0]    s1_ll_q, s1_ll_d;
  logic [CH_W-1:0] s1_ch_q, s1_ch_d;
  logic            s2_valid_q, s2_valid_d;
  logic [W-1:0]    a1p_q, a1p_d;
  logic [CH_W-1:0] s2_ch_q, s2_ch_d;
  logic            s2_hi_q, s2_hi_d;
  logic            s2_lo_q, s2_lo_d;

  logic            advance;
  logic            s2_load;
  logic [W-1:0]    a1ul;
  logic [W-1:0]    a1ll;
  logic            lo_hit;
  logic            hi_hit;
  logic [W-1:0]    a1p_sel;

  // The whole pipe moves as one unit; a stalled output freezes S1 as well.
  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance;
  assign s2_load  = advance && s1_valid_q;

  assign a1ul = OME_W - A2P;
  assign a1ll = '0 - a1ul;

  assign lo_hit  = s1_a1t_q[W-1] && (s1_a1t_q <= s1_ll_q);
  assign hi_hit  = !s1_a1t_q[W-1] && (s1_a1t_q >= s1_ul_q);
  assign a1p_sel = lo_hit ? s1_ll_q : (hi_hit ? s1_ul_q : s1_a1t_q);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a1t_d   = s1_a1t_q;
    s1_ul_d    = s1_ul_q;
    s1_ll_d    = s1_ll_q;
    s1_ch_d    = s1_ch_q;
    s2_valid_d = s2_valid_q;
    a1p_d      = a1p_q;
    s2_ch_d    = s2_ch_q;
    s2_hi_d    = s2_hi_q;
    s2_lo_d    = s2_lo_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_a1t_d = A1T;
        s1_ul_d  = a1ul;
        s1_ll_d  = a1ll;
        s1_ch_d  = in_ch;
      end
      if (s1_valid_q) begin
        a1p_d   = a1p_sel;
        s2_ch_d = s1_ch_q;
        s2_hi_d = hi_hit;
        s2_lo_d = lo_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_a1t_q   <= '0;
      s1_ul_q    <= '0;
      s1_ll_q    <= '0;
      s1_ch_q    <= '0;
      s2_valid_q <= 1'b0;
      a1p_q      <= '0;
      s2_ch_q    <= '0;
      s2_hi_q    <= 1'b0;
      s2_lo_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a1t_q   <= s1_a1t_d;
      s1_ul_q    <= s1_ul_d;
      s1_ll_q    <= s1_ll_d;
      s1_ch_q    <= s1_ch_d;
      s2_valid_q <= s2_valid_d;
      a1p_q      <= a1p_d;
      s2_ch_q    <= s2_ch_d;
      s2_hi_q    <= s2_hi_d;
      s2_lo_q    <= s2_lo_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ch    = s2_ch_q;
  assign A1P       = a1p_q;

`ifdef LIMD_CLAMP_FLAG_EN
  assign out_clamp = {s2_hi_q, s2_lo_q};
`else
  assign out_clamp = 2'b00;
`endif

  logic [NCH-1:0][CNT_W-1:0] cnt_all;

  // Channel ids at or above NCH match no counter slot, so they never count.
  for (genvar c = 0; c < NCH; c++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (s2_load && (hi_hit || lo_hit) && (s1_ch_q == CH_W'(c)) && (cnt_q != '1))
        cnt_d = cnt_q + CNT_W'(1);
      if (stat_clr && (stat_ch == CH_W'(c)))
        cnt_d = '0;
    end

    always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign cnt_all[c] = cnt_q;
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (stat_ch == CH_W'(i)) stat_cnt = cnt_all[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_limd_mc.sv
`default_nettype none
// ============================================================================
// tb_limd_mc : directed vector bench for limd_mc (NCH=4, CNT_W=4).
// Revision: 1.0
// ============================================================================
module tb_limd_mc;

  localparam int W     = 16;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;
  localparam int CH_W  = 2;
  localparam int NV    = 12;

  logic             clk;
  logic             reset;
  logic             scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_ch;
  logic [W-1:0]     A1T;
  logic [W-1:0]     A2P;
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [W-1:0]     A1P;
  logic [1:0]       out_clamp;
  logic [CH_W-1:0]  stat_ch;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_cnt;

  limd_mc #(.W(W), .OME(15360), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
    .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .A1T(A1T), .A2P(A2P),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .A1P(A1P),
    .out_clamp(out_clamp), .stat_ch(stat_ch), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  typedef struct {
    logic [W-1:0] a1t;
    logic [W-1:0] a2p;
    logic [W-1:0] a1p;
    logic         hi;
    logic         lo;
  } vec_t;

  vec_t tbl [NV];
  int   checks   = 0;
  int   failures = 0;
  int   cnt_exp [NCH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int ch, input int idx);
    in_valid = v;
    in_ch    = CH_W'(ch);
    A1T      = tbl[idx].a1t;
    A2P      = tbl[idx].a2p;
  endtask

  function automatic logic [1:0] flags_exp(input logic hi, input logic lo);
`ifdef LIMD_CLAMP_FLAG_EN
    return {hi, lo};
`else
    return 2'b00;
`endif
  endfunction

  task automatic chk_cnt(input string name, input int ch, input int exp);
    stat_ch = CH_W'(ch);
    #1;
    chk(name, 32'(stat_cnt), 32'(exp));
  endtask

  initial begin : main
    int q_idx [$];
    int q_ch [$];
    int sent, got, idx, ch;
    logic [W-1:0]    prev_a1p;
    logic [CH_W-1:0] prev_ch;
    bit              prev_stall;

    //           a1t       a2p       a1p       hi    lo
    tbl[0]  = '{16'h4000, 16'h0000, 16'h3C00, 1'b1, 1'b0};
    tbl[1]  = '{16'hC000, 16'h0000, 16'hC400, 1'b0, 1'b1};
    tbl[2]  = '{16'h5000, 16'hE000, 16'h5000, 1'b0, 1'b0};
    tbl[3]  = '{16'h3BFF, 16'h0000, 16'h3BFF, 1'b0, 1'b0};
    tbl[4]  = '{16'h3C00, 16'h0000, 16'h3C00, 1'b1, 1'b0};
    tbl[5]  = '{16'hC400, 16'h0000, 16'hC400, 1'b0, 1'b1};
    tbl[6]  = '{16'hC401, 16'h0000, 16'hC401, 1'b0, 1'b0};
    tbl[7]  = '{16'h1C01, 16'h2000, 16'h1C00, 1'b1, 1'b0};
    tbl[8]  = '{16'hE000, 16'h2000, 16'hE400, 1'b0, 1'b1};
    tbl[9]  = '{16'h8000, 16'hD000, 16'h9400, 1'b0, 1'b1};
    tbl[10] = '{16'h7000, 16'hD000, 16'h6C00, 1'b1, 1'b0};
    tbl[11] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    for (int c = 0; c < NCH; c++) cnt_exp[c] = 0;

    reset = 1'b0; in_valid = 1'b0; in_ch = '0; A1T = '0; A2P = '0;
    out_ready = 1'b1; stat_ch = '0; stat_clr = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a1p", 32'(A1P), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_clamp", 32'(out_clamp), 32'd0);
    for (int c = 0; c < NCH; c++) chk_cnt("rst_cnt", c, 0);
    reset = 1'b1;

    // Full-rate interleave: every vector checked exactly two cycles after acceptance.
    for (int k = 0; k < NV + 2; k++) begin
      step();
      out_ready = 1'b1;
      if (k < NV) begin
        drive(1'b1, k % NCH, k);
        cnt_exp[k % NCH] += (tbl[k].hi || tbl[k].lo) ? 1 : 0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("rate_in_ready", 32'(in_ready), 32'd1);
      if (k >= 2) begin
        chk("rate_out_valid", 32'(out_valid), 32'd1);
        chk("rate_a1p", 32'(A1P), 32'(tbl[k-2].a1p));
        chk("rate_out_ch", 32'(out_ch), 32'((k - 2) % NCH));
        chk("rate_clamp", 32'(out_clamp), 32'(flags_exp(tbl[k-2].hi, tbl[k-2].lo)));
      end else begin
        chk("rate_out_valid_fill", 32'(out_valid), 32'd0);
      end
    end
    step();
    in_valid = 1'b0;
    for (int c = 0; c < NCH; c++) chk_cnt("rate_cnt", c, cnt_exp[c]);

    // Backpressure with a 3-cycle stall mid-stream.
    sent = 0; got = 0; prev_stall = 1'b0; prev_a1p = '0; prev_ch = '0;
    for (int s = 0; s < 40; s++) begin
      step();
      out_ready = !(s >= 3 && s <= 5);
      if (sent < 8) drive(1'b1, (sent + 1) % NCH, sent + 2);
      else          in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        chk("stall_a1p", 32'(A1P), 32'(prev_a1p));
        chk("stall_out_ch", 32'(out_ch), 32'(prev_ch));
      end
      chk("bp_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (q_idx.size() == 0) begin
          chk("bp_unexpected_out", 32'd1, 32'd0);
        end else begin
          idx = q_idx.pop_front();
          ch  = q_ch.pop_front();
          chk("bp_a1p", 32'(A1P), 32'(tbl[idx].a1p));
          chk("bp_out_ch", 32'(out_ch), 32'(ch));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q_idx.push_back(sent + 2);
        q_ch.push_back((sent + 1) % NCH);
        cnt_exp[(sent + 1) % NCH] += (tbl[sent+2].hi || tbl[sent+2].lo) ? 1 : 0;
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_a1p   = A1P;
      prev_ch    = out_ch;
      if (sent == 8 && got == 8) break;
    end
    chk("bp_outputs_received", 32'(got), 32'd8);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    for (int c = 0; c < NCH; c++) chk_cnt("bp_cnt", c, cnt_exp[c]);

    // Saturation and clear on ch2.
    step(); stat_ch = 2'd2; stat_clr = 1'b1;
    step(); stat_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2, 0);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk_cnt("sat_cnt_ch2", 2, 15);
    chk_cnt("sat_cnt_ch0", 0, cnt_exp[0]);
    stat_ch = 2'd2; stat_clr = 1'b1;
    step(); stat_clr = 1'b0;
    chk_cnt("clr_cnt_ch2", 2, 0);
    drive(1'b1, 2, 0);
    step(); in_valid = 1'b0;
    step();
    chk_cnt("inc_after_clr", 2, 1);
    drive(1'b1, 2, 0);
    step(); in_valid = 1'b0; stat_ch = 2'd2; stat_clr = 1'b1;
    step(); stat_clr = 1'b0;
    chk_cnt("clr_wins", 2, 0);

    // Reset with two clamping samples in flight.
    drive(1'b1, 0, 0);
    step(); drive(1'b1, 1, 1);
    step(); in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    step();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_a1p", 32'(A1P), 32'd0);
    for (int c = 0; c < NCH; c++) chk_cnt("mid_rst_cnt", c, 0);
    reset = 1'b1;
    step();
    chk("post_rst_no_ghost", 32'(out_valid), 32'd0);
    drive(1'b1, 3, 2);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_a1p", 32'(A1P), 32'h5000);
    chk("post_rst_out_ch", 32'(out_ch), 32'd3);
    chk_cnt("post_rst_cnt_ch0", 0, 0);
    chk_cnt("post_rst_cnt_ch3", 3, 0);
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
